// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit add/subtract sequencer built around a single shared
// 4-bit ripple-carry adder slice. One nibble is processed per clock; the
// inter-nibble carry is registered. start/busy/done handshake.

// 4-bit ripple-carry adder slice.
module rca4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    // Ripple the carry through four full-adder cells.
    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

module nibble_add_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = $clog2(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // B, or ~B in subtract mode
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CW+1:0]    base;
    logic [3:0]       slice_a, slice_b, slice_sum;
    logic             slice_cout;

    assign base    = {cnt_q, 2'b00};
    assign slice_a = a_q[base +: 4];
    assign slice_b = b_q[base +: 4];

    rca4_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state, operand capture and progressive result assembly.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Two's-complement subtract: invert B, carry-in of 1.
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[base +: 4] = slice_sum;
                carry_d             = slice_cout;
                if (cnt_q == LAST) begin
                    // Final nibble: slice_sum[3] is the result MSB.
                    state_d = DONE;
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_sum[3] != a_q[WIDTH-1]);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq: the driver predicts acceptance and
// pushes expected results; a negedge monitor checks busy/done every cycle
// and pops/compares results on done.
module tb_nibble_add_seq;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    nibble_add_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   last_acc = -1000;
    int   errors   = 0;
    int   checks   = 0;
    bit   mon_en   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic.
    function automatic void ref_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic c, output logic v);
        int sa, sbv, sr;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        sr  = s ? sa - sbv : sa + sbv;
        v   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        r   = s ? a - b : a + b;
        c   = s ? (a >= b) : ((int'(a) + int'(b)) > (1 << W) - 1);
    endfunction

    // Monitor: busy/done every cycle, result fields on done.
    always @(negedge clk) begin : mon
        bit   dexp;
        exp_t e;
        if (mon_en && !rst) begin
            dexp = (sb.size() > 0) && (sb[0].due == cyc);
            chk("busy", busy, (cyc >= last_acc) && (cyc <= last_acc + NIB - 1));
            chk("done", done, dexp);
            if (dexp) begin
                e = sb.pop_front();
                if (done) begin
                    chk("result", result, e.r);
                    chk("cout", cout, e.c);
                    chk("ovf", ovf, e.v);
                end
            end
        end
    end

    // One cycle of stimulus; start sampled at the next rising edge.
    task automatic drive(input bit st, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         c, v;
        @(negedge clk);
        start = st;
        sub   = s;
        A     = a;
        B     = b;
        if (st && (cyc + 1) >= last_acc + NIB + 1) begin
            ref_op(s, a, b, r, c, v);
            sb.push_back('{r: r, c: c, v: v, due: cyc + 1 + NIB});
            last_acc = cyc + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, W'($urandom), W'($urandom));
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_cout"}, cout, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: pick = '0;
            1: pick = '1;
            2: pick = W'(1) << (W - 1);
            3: pick = ~(W'(1) << (W - 1));
            default: pick = W'($urandom);
        endcase
    endfunction

    initial begin
        #1 rst = 1'b1;
        #1 reset_check("reset");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        mon_en = 1;

        // Basic add, carry ripple, overflow cases.
        drive(1, 0, 16'h1234, 16'h4321); idle(5);
        drive(1, 0, 16'hFFFF, 16'h0001); idle(5);
        drive(1, 0, 16'h7FFF, 16'h0001); idle(5);
        drive(1, 1, 16'h8000, 16'h0001); idle(5);

        // Borrow case with start held high: back-to-back from DONE only.
        for (int i = 0; i < 12; i++) drive(1, 1, 16'h0005, 16'h0007);
        idle(6);

        // Second start during RUN is ignored.
        drive(1, 0, 16'h1111, 16'h2222);
        drive(0, 0, 16'hAAAA, 16'h5555);
        drive(1, 1, 16'hDEAD, 16'hBEEF);
        idle(6);

        // Asynchronous reset in RUN cycle 3.
        drive(1, 0, 16'hFFFF, 16'hFFFF);
        drive(0, 0, 16'h0, 16'h0);
        drive(0, 0, 16'h0, 16'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
        last_acc = -1000;
        #1 reset_check("midrun_rst");
        @(negedge clk);
        #2 rst = 1'b0;
        idle(3);
        drive(1, 1, 16'h1000, 16'h0001); idle(6);

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 2) == 0, 1'($urandom), pick(), pick());

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        chk("drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
